// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between the single-cycle datapath and a req/ack data memory.
// Stores are lane-aligned with byte enables; loads are lane-selected and sign/zero-extended.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [31:0]       addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              bus_cause;
  logic [31:0]       read_data;
  logic              start;
  logic              legal;

  function automatic logic legal_start(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic ok_f3;
    logic misaligned;
    case (f3)
      3'b000, 3'b001, 3'b010: ok_f3 = 1'b1;
      3'b100, 3'b101:         ok_f3 = !st;
      default:                ok_f3 = 1'b0;
    endcase
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return ok_f3 && !misaligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic        [31:0] lane;
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    lane  = rdata >> {a, 3'b000};
    sbyte = $signed(lane[7:0]);
    shalf = $signed(lane[15:0]);
    case (f3)
      3'b000:  return 32'(sbyte);
      3'b001:  return 32'(shalf);
      3'b100:  return {24'h0, lane[7:0]};
      3'b101:  return {16'h0, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign start = MemRead | MemWrite;
  assign legal = legal_start(MemWrite, funct3, ALUResult[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = legal ? ACCESS : ERR;
      ACCESS:  if (mem_ack) state_nxt = DONE;
               else if (cnt == CNT_LAST) state_nxt = ERR;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at start so they stay stable for the whole access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      bus_cause <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            bus_cause <= 1'b0;
            cnt       <= '0;
            if (legal) begin
              addr_q  <= ALUResult;
              f3_q    <= funct3;
              we_q    <= MemWrite;
              be_q    <= MemWrite ? store_be(funct3, ALUResult[1:0]) : 4'b1111;
              wdata_q <= MemWrite ? store_wdata(funct3, WriteData) : 32'h0;
            end else if (!MemWrite) begin
              read_data <= '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            if (!we_q) read_data <= extend_load(f3_q, addr_q[1:0], mem_rdata);
          end else if (cnt == CNT_LAST) begin
            bus_cause <= 1'b1;
            if (!we_q) read_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadData  = read_data;
  assign Stall     = ((state == IDLE) && start) || (state == ACCESS);
  assign AccessErr = (state == ERR) && !bus_cause;
  assign BusErr    = (state == ERR) && bus_cause;
  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = mem_req ? be_q : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule
